// File: rtl/spike_pkg.sv
// Shared constants and helpers for the spike event path. The node outputs feed
// this path, and it feeds the pin serializer.
package spike_pkg;

  localparam int VAL_W   = 4;
  localparam int VAL_LSB = 0;
  localparam int ID_LSB  = VAL_W;
  localparam int DROP_W  = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Timestamp field sits above {node_id, value}.
  function automatic int ts_lsb(input int id_w);
    return VAL_W + id_w;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous show-ahead FIFO. The head word is registered, so dout holds its
// last value while the FIFO is empty.
module evt_fifo
  import spike_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_next;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign w_push    = push && !full;
  assign w_pop     = pop && !empty;
  assign w_rd_next = r_rd_ptr + AW'(1);
  assign dout      = r_dout;
  assign count     = r_count;

  // NOTE: storage array is deliberately left out of reset; the pointers and
  // count decide which entries are meaningful, and a reset here would stop
  // the array from mapping onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // NOTE: every register here uses <= so all of them sample pre-edge values;
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: ;
      endcase
      if (w_pop) begin
        if (r_count == ONE_CNT) begin
          if (w_push) r_dout <= din;
        end else begin
          r_dout <= r_mem[w_rd_next];
        end
      end else if (empty && w_push) begin
        r_dout <= din;
      end
    end
  end

endmodule

// File: rtl/spike_event_fifo.sv
// Turns each new non-zero node output into a timestamped event. Events are
// held per node, arbitrated round-robin into a FIFO, and streamed out valid/ready.
module spike_event_fifo
  import spike_pkg::*;
#(
  parameter int NODES = 4,
  parameter int DEPTH = 8,
  parameter int TS_W  = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [4*NODES-1:0]                 node_out,
  output logic                               evt_valid,
  output logic [TS_W+clog2(NODES)+VAL_W-1:0] evt_data,
  input  logic                               evt_ready,
  output logic [clog2(DEPTH):0]              fifo_count,
  output logic [DROP_W-1:0]                  drop_cnt
);

  localparam int ID_W   = clog2(NODES);
  localparam int EVT_W  = TS_W + ID_W + VAL_W;
  localparam int TS_LSB = ts_lsb(ID_W);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NODES - 1);

  logic [TS_W-1:0]   r_ts;
  logic [VAL_W-1:0]  r_prev [NODES];
  logic [NODES-1:0]  r_pend;
  logic [VAL_W-1:0]  r_pval [NODES];
  logic [TS_W-1:0]   r_pts  [NODES];
  logic [ID_W-1:0]   r_rr_ptr;
  logic [DROP_W-1:0] r_drop;

  logic [VAL_W-1:0]  w_node [NODES];
  logic [NODES-1:0]  w_det;
  logic [NODES-1:0]  w_grant_oh;
  logic              w_grant;
  logic [ID_W-1:0]   w_grant_id;
  logic              w_full;
  logic              w_empty;
  logic [DROP_W-1:0] w_drop_next;
  logic [EVT_W-1:0]  w_push_word;

  // NOTE: each always_comb assigns every output before any condition, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      w_node[n] = node_out[VAL_W*n +: VAL_W];
      w_det[n]  = (w_node[n] != '0) && (w_node[n] != r_prev[n]);
    end
  end

  // Round-robin search starting at r_rr_ptr; a full FIFO blocks all grants.
  always_comb begin
    w_grant    = 1'b0;
    w_grant_id = '0;
    w_grant_oh = '0;
    for (int k = 0; k < NODES; k++) begin : g_search
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] sel;
      sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NODES)) sum = sum - (ID_W+1)'(NODES);
      sel = sum[ID_W-1:0];
      if (!w_grant && !w_full && r_pend[sel]) begin
        w_grant         = 1'b1;
        w_grant_id      = sel;
        w_grant_oh[sel] = 1'b1;
      end
    end
  end

  // A re-detect on a node that is pending and not being granted loses the old event.
  always_comb begin
    int n_drop;
    int total;
    n_drop = 0;
    for (int n = 0; n < NODES; n++) begin
      if (w_det[n] && r_pend[n] && !w_grant_oh[n]) n_drop++;
    end
    total       = int'(r_drop) + n_drop;
    w_drop_next = (total > int'(DROP_MAX)) ? DROP_MAX : DROP_W'(total);
  end

  always_comb begin
    w_push_word                       = '0;
    w_push_word[VAL_LSB +: VAL_W]     = r_pval[w_grant_id];
    w_push_word[ID_LSB +: ID_W]       = w_grant_id;
    w_push_word[TS_LSB +: TS_W]       = r_pts[w_grant_id];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts     <= '0;
      r_pend   <= '0;
      r_rr_ptr <= '0;
      r_drop   <= '0;
      for (int n = 0; n < NODES; n++) r_prev[n] <= '0;
    end else begin
      r_ts   <= r_ts + TS_W'(1);
      r_drop <= w_drop_next;
      if (w_grant) r_rr_ptr <= (w_grant_id == LAST_ID) ? '0 : w_grant_id + ID_W'(1);
      for (int n = 0; n < NODES; n++) r_prev[n] <= w_node[n];
      r_pend <= (r_pend & ~w_grant_oh) | w_det;
    end
  end

  // Payload is only read while its pend bit is set.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NODES; n++) begin
      if (w_det[n]) begin
        r_pval[n] <= w_node[n];
        r_pts[n]  <= r_ts;
      end
    end
  end

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_grant),
    .din   (w_push_word),
    .full  (w_full),
    .pop   (evt_ready),
    .dout  (evt_data),
    .empty (w_empty),
    .count (fifo_count)
  );

  assign evt_valid = !w_empty;
  assign drop_cnt  = r_drop;

endmodule

// File: doc/spike_event_fifo.md
Name: spike_event_fifo

Overview:
Downstream consumer of the node wrappers in the neuron fabric. Samples the 4-bit outputs of NODES wrapped LIF nodes every clock and turns each new non-zero output into a timestamped event. Events are buffered in a FIFO and streamed out over a valid/ready interface. That interface feeds the pin serializer that drives the chip's output pins.

Parameters:
NODES, 4, number of monitored node outputs (2..16)
DEPTH, 8, FIFO depth in events (power of two, >=2)
TS_W, 6, timestamp width in bits
ID_W, derived clog2(NODES), node-id field width (localparam, not overridable)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
node_out  input  4*NODES  concatenated node outputs, node n at bits [4n+3:4n]
evt_valid  output  1  head event available
evt_data  output  TS_W+ID_W+4  event word {ts, node_id, value}
evt_ready  input  1  consumer accepts head event
fifo_count  output  clog2(DEPTH)+1  events currently buffered
drop_cnt  output  8  saturating count of lost events

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high.
  - Clears the timestamp, prev regs, pending bits, round-robin pointer, FIFO pointers, count and drop_cnt.
  - Outputs after reset: evt_valid=0, evt_data=0, fifo_count=0, drop_cnt=0.
  - Reset asserted mid-operation discards all buffered and pending events.
- Timestamp: free-running TS_W counter, +1 every non-reset cycle, wraps 2^TS_W-1 -> 0.
- Detect, per node n, each cycle:
  - prev_n <= node_out_n.
  - det_n = (node_out_n != 0) && (node_out_n != prev_n).
  - A constant non-zero output therefore yields exactly one event.
  - A change between two non-zero values yields a new event.
- Pending stage, per node: pend_n, pval_n[3:0], pts_n[TS_W-1:0].
  - det_n with pend_n=0: set pend_n, capture value and current ts.
  - det_n with pend_n=1 and not granted this cycle: overwrite pval/pts, drop_cnt+1 (saturates at 255).
  - det_n on a node granted the same cycle: the grant pushes the old contents and the new detect is captured. No drop.
- Arbiter: round-robin over pending nodes, starting at rr_ptr.
  - Grants at most one push per cycle, and only when fifo_count < DEPTH.
  - On grant of node g: pend_g cleared (unless re-set by a same-cycle det), and rr_ptr <= g+1 mod NODES.
  - No grant: rr_ptr holds.
- Push word = {pts_g, g[ID_W-1:0], pval_g}.
- Detect-to-FIFO latency: detect at cycle t -> pend at t+1 -> push at t+1 if granted -> evt_valid at t+2.
- FIFO: show-ahead.
  - evt_valid = (count != 0); evt_data = head word.
  - evt_data holds when evt_valid=0.
  - Pop when evt_valid && evt_ready.
  - Push and pop in the same cycle are allowed when not empty; count unchanged.
  - When full, no push occurs even if a pop happens that cycle. The grant is deferred one cycle, which keeps the full-flag path registered.
  - Empty plus push: the word appears at the head the next cycle (no bypass).
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Backpressure: with evt_ready held low, the FIFO fills and events then queue in the pending regs. Only re-detects on already-pending nodes are dropped.
- evt_data must stay stable while evt_valid=1 and evt_ready=0.

Decomposition:
- Shared package, spike_pkg:
  - event field widths and offsets (VAL_W=4, the TS/ID field positions)
  - the drop counter width constant
  - function clog2
- One sub-module: evt_fifo, a synchronous show-ahead FIFO with parameters WIDTH and DEPTH, ports push/din/full, pop/dout/empty and count.
- Detect, pending and arbitration logic stays in the top module.

Test Plan:
- Reset then idle, node_out=0 for 20 cycles -> evt_valid=0, fifo_count=0, drop_cnt=0 throughout.
- Node 2 goes to 4'h5 at ts=3 and holds for 10 cycles, evt_ready=1 -> exactly one event, {ts=3, id=2, val=5}, valid 2 cycles after the edge.
- Nodes 0, 1 and 3 detect in the same cycle with rr_ptr=0 and ready=1 -> events leave in order id 0, 1, 3, on consecutive cycles, all with the same ts.
- evt_ready=0, node 0 toggles 0<->4'h1 every 2 cycles for 40 cycles -> fifo_count reaches 8 and stops. Node 0 stays pending; each later detect raises drop_cnt by 1. After ready=1, 9 events drain in order.
- drop_cnt driven past 255 -> holds at 255.
- Reset asserted with 5 events buffered and 2 pending -> next cycle evt_valid=0 and fifo_count=0. No stale events appear after reset is released.
